// File: rtl/pyramid_scan_sequencer.sv
// Sequencer for the Gaussian-pyramid blur datapath: per octave, raster-scans every pixel of every
// blur level, fetches the edge-clamped 3x3 kernel, hands it to the blur unit and writes the result back.
module pyramid_scan_sequencer #(
  parameter int unsigned BIT_DEPTH   = 8,
  parameter int unsigned IMG_W       = 128,
  parameter int unsigned NUM_OCTAVES = 4,
  parameter int unsigned NUM_BLURS   = 5,
  parameter int unsigned ADDR_W      = $clog2(2*IMG_W*IMG_W)
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   go_in,
  output logic                   rd_en_out,
  output logic [ADDR_W-1:0]      rd_addr_out,
  output logic [1:0]             rd_octave_out,
  input  logic [BIT_DEPTH-1:0]   pixel_in,
  output logic [3*BIT_DEPTH-1:0] row0_out,
  output logic [3*BIT_DEPTH-1:0] row1_out,
  output logic [3*BIT_DEPTH-1:0] row2_out,
  output logic                   kernel_valid_out,
  input  logic                   blur_valid_in,
  input  logic [BIT_DEPTH-1:0]   blur_pixel_in,
  output logic                   wr_en_out,
  output logic [ADDR_W-1:0]      wr_addr_out,
  output logic [BIT_DEPTH-1:0]   wr_data_out,
  output logic [2:0]             blur_level_out,
  output logic                   octave_done_out,
  output logic                   pyramid_done_out,
  output logic                   busy_out,
  output logic                   error_out
);

  localparam int unsigned XW         = $clog2(IMG_W);
  localparam int unsigned RW         = 3*BIT_DEPTH;
  localparam int unsigned FETCH_LAST = 10;
  localparam int unsigned TAP_LAST   = 8;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_WRITE, S_ADV} state_e;

  state_e            state_q, state_d;
  logic [3:0]        fcnt_q, fcnt_d;
  logic [XW-1:0]     x_q, x_d, y_q, y_d;
  logic [2:0]        lvl_q, lvl_d;
  logic [1:0]        oct_q, oct_d;
  logic              rd_en_q, rd_en_d, kv_q, kv_d, wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [1:0]        rd_oct_q, rd_oct_d;
  logic [RW-1:0]     row0_q, row0_d, row1_q, row1_d, row2_q, row2_d, cap_row;
  logic [BIT_DEPTH-1:0] wr_data_q, wr_data_d;
  logic [2:0]        blvl_q, blvl_d;
  logic              oct_done_q, oct_done_d, pyr_done_q, pyr_done_d;
  logic              busy_q, busy_d, err_q, err_d;
  logic [ADDR_W-1:0] w_cur, w_nxt, rx, ry;
  logic [3:0]        tap, cap;
  logic              x_last, y_last, lvl_last, oct_last, px_last;

  // Tap index 0..8 -> {row, col} of the 3x3 kernel, row-major.
  function automatic logic [3:0] tap_pos(input logic [3:0] idx);
    if (idx < 4'd3)      return {2'd0, idx[1:0]};
    else if (idx < 4'd6) return {2'd1, 2'(idx - 4'd3)};
    else                 return {2'd2, 2'(idx - 4'd6)};
  endfunction

  // Neighbour coordinate for kernel offset k (0:-1, 1:0, 2:+1), saturated to [0, w-1].
  function automatic logic [ADDR_W-1:0] clamp_step(input logic [ADDR_W-1:0] v, input logic [1:0] k,
                                                   input logic [ADDR_W-1:0] w);
    case (k)
      2'd0:    return (v == '0) ? v : v - ADDR_W'(1);
      2'd2:    return (v == w - ADDR_W'(1)) ? v : v + ADDR_W'(1);
      default: return v;
    endcase
  endfunction

  assign w_cur    = ADDR_W'(IMG_W) >> oct_q;
  assign x_last   = (ADDR_W'(x_q) == w_cur - ADDR_W'(1));
  assign y_last   = (ADDR_W'(y_q) == w_cur - ADDR_W'(1));
  assign lvl_last = (lvl_q == 3'(NUM_BLURS - 1));
  assign oct_last = (oct_q == 2'(NUM_OCTAVES - 1));
  assign px_last  = x_last & y_last & lvl_last;

  always_ff @(posedge clk_in or negedge rst_n_in) begin : state_reg
    if (!rst_n_in) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (go_in) state_d = S_FETCH;
      S_FETCH: if (fcnt_q == 4'(FETCH_LAST)) state_d = S_WAIT;
      S_WAIT:  if (blur_valid_in) state_d = S_WRITE;
      S_WRITE: state_d = S_ADV;
      S_ADV:   state_d = px_last ? S_IDLE : S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : outputs
    fcnt_d = '0;
    x_d = x_q; y_d = y_q; lvl_d = lvl_q; oct_d = oct_q;
    row0_d = row0_q; row1_d = row1_q; row2_d = row2_q;
    cap = '0; cap_row = '0;
    wr_addr_d = wr_addr_q; wr_data_d = wr_data_q; blvl_d = blvl_q;
    pyr_done_d = pyr_done_q;

    if (state_q == S_FETCH && state_d == S_FETCH) fcnt_d = fcnt_q + 4'd1;

    if (state_q == S_ADV) begin
      if (!x_last) x_d = x_q + XW'(1);
      else begin
        x_d = '0;
        if (!y_last) y_d = y_q + XW'(1);
        else begin
          y_d = '0;
          if (!lvl_last) lvl_d = lvl_q + 3'd1;
          else begin
            lvl_d = '0;
            oct_d = oct_last ? 2'd0 : oct_q + 2'd1;
          end
        end
      end
    end

    // Read address is launched one cycle ahead, so it is built from the next-cycle counters.
    w_nxt     = ADDR_W'(IMG_W) >> oct_d;
    tap       = tap_pos(fcnt_d);
    rx        = clamp_step(ADDR_W'(x_d), tap[1:0], w_nxt);
    ry        = clamp_step(ADDR_W'(y_d), tap[3:2], w_nxt);
    rd_en_d   = (state_d == S_FETCH) && (fcnt_d <= 4'(TAP_LAST));
    rd_addr_d = rd_addr_q;
    if (rd_en_d) rd_addr_d = (lvl_d[0] ? w_nxt * w_nxt : '0) + ry * w_nxt + rx;
    rd_oct_d  = oct_d;

    // Read data returns two cycles after its request; drop it into the matching kernel slot.
    if (state_q == S_FETCH && fcnt_q >= 4'd2) begin
      cap = tap_pos(fcnt_q - 4'd2);
      cap_row = (cap[3:2] == 2'd0) ? row0_q : (cap[3:2] == 2'd1) ? row1_q : row2_q;
      case (cap[1:0])
        2'd0:    cap_row[RW-1 -: BIT_DEPTH]          = pixel_in;
        2'd1:    cap_row[2*BIT_DEPTH-1 -: BIT_DEPTH] = pixel_in;
        default: cap_row[BIT_DEPTH-1:0]              = pixel_in;
      endcase
      case (cap[3:2])
        2'd0:    row0_d = cap_row;
        2'd1:    row1_d = cap_row;
        default: row2_d = cap_row;
      endcase
    end

    kv_d    = (state_q == S_FETCH) && (state_d == S_WAIT);
    wr_en_d = (state_q == S_WAIT) && blur_valid_in;
    if (wr_en_d) begin
      wr_addr_d = (lvl_q[0] ? '0 : w_cur * w_cur) + ADDR_W'(y_q) * w_cur + ADDR_W'(x_q);
      wr_data_d = blur_pixel_in;
      blvl_d    = lvl_q;
    end

    oct_done_d = (state_q == S_WRITE) && px_last;
    if (state_q == S_IDLE && go_in)                      pyr_done_d = 1'b0;
    else if (state_q == S_WRITE && px_last && oct_last)  pyr_done_d = 1'b1;

    busy_d = (state_d != S_IDLE);
    err_d  = err_q | (blur_valid_in & (state_q != S_WAIT));
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin : datapath
    if (!rst_n_in) begin
      fcnt_q <= '0; x_q <= '0; y_q <= '0; lvl_q <= '0; oct_q <= '0;
      rd_en_q <= 1'b0; rd_addr_q <= '0; rd_oct_q <= '0;
      row0_q <= '0; row1_q <= '0; row2_q <= '0; kv_q <= 1'b0;
      wr_en_q <= 1'b0; wr_addr_q <= '0; wr_data_q <= '0; blvl_q <= '0;
      oct_done_q <= 1'b0; pyr_done_q <= 1'b0; busy_q <= 1'b0; err_q <= 1'b0;
    end else begin
      fcnt_q <= fcnt_d; x_q <= x_d; y_q <= y_d; lvl_q <= lvl_d; oct_q <= oct_d;
      rd_en_q <= rd_en_d; rd_addr_q <= rd_addr_d; rd_oct_q <= rd_oct_d;
      row0_q <= row0_d; row1_q <= row1_d; row2_q <= row2_d; kv_q <= kv_d;
      wr_en_q <= wr_en_d; wr_addr_q <= wr_addr_d; wr_data_q <= wr_data_d; blvl_q <= blvl_d;
      oct_done_q <= oct_done_d; pyr_done_q <= pyr_done_d; busy_q <= busy_d; err_q <= err_d;
    end
  end

  assign rd_en_out        = rd_en_q;
  assign rd_addr_out      = rd_addr_q;
  assign rd_octave_out    = rd_oct_q;
  assign row0_out         = row0_q;
  assign row1_out         = row1_q;
  assign row2_out         = row2_q;
  assign kernel_valid_out = kv_q;
  assign wr_en_out        = wr_en_q;
  assign wr_addr_out      = wr_addr_q;
  assign wr_data_out      = wr_data_q;
  assign blur_level_out   = blvl_q;
  assign octave_done_out  = oct_done_q;
  assign pyramid_done_out = pyr_done_q;
  assign busy_out         = busy_q;
  assign error_out        = err_q;

endmodule

// File: doc/pyramid_scan_sequencer.md
# pyramid_scan_sequencer

Control FSM that drives the Gaussian-pyramid blur datapath. For each octave it raster-scans every pixel of every blur level. For each center pixel it:
- issues the nine edge-saturated 3x3 kernel reads to that octave's ping-pong frame buffer,
- hands the packed kernel rows to the `gaussian` blur unit,
- writes the blurred result into the opposite buffer half.

It sits between the per-octave dual-port BRAMs and `gaussian`. Image loading and downsampling are handled elsewhere; this block waits for `go_in` before each octave.

## Interface
- `BIT_DEPTH`, 8, pixel width
- `IMG_W`, 128, octave-0 image width = height (power of two, ≥16)
- `NUM_OCTAVES`, 4, octaves processed; octave o has width `IMG_W>>o`
- `NUM_BLURS`, 5, blurred images produced per octave
- `ADDR_W`, `$clog2(2*IMG_W*IMG_W)`, BRAM address width
- `clk_in` input 1 — sole clock
- `rst_n_in` input 1 — asynchronous, active-low reset
- `go_in` input 1 — pulse: start processing the current octave (source image already in half 0)
- `rd_en_out` output 1 — BRAM port-B read enable
- `rd_addr_out` output `ADDR_W` — read address
- `rd_octave_out` output 2 — selects frame buffer for both read and write
- `pixel_in` input `BIT_DEPTH` — BRAM read data, valid exactly 2 cycles after `rd_en_out`
- `row0_out`, `row1_out`, `row2_out` output `3*BIT_DEPTH` each — kernel rows (top/mid/bottom); `[3B-1:2B]`=left, `[2B-1:B]`=center, `[B-1:0]`=right
- `kernel_valid_out` output 1 — one-cycle pulse; rows valid
- `blur_valid_in` input 1 — blur result strobe
- `blur_pixel_in` input `BIT_DEPTH` — blur result
- `wr_en_out` output 1 — port-A write enable
- `wr_addr_out` output `ADDR_W` — write address
- `wr_data_out` output `BIT_DEPTH` — write data
- `blur_level_out` output 3 — blur level of the current write (pyramid tap tag)
- `octave_done_out` output 1 — one-cycle pulse after an octave's last write
- `pyramid_done_out` output 1 — high after the final octave; cleared by the next `go_in`
- `busy_out` output 1 — high in any state except IDLE
- `error_out` output 1 — sticky; set by `blur_valid_in` outside WAIT_BLUR

## Operation
**States:**
- IDLE —`go_in`→ FETCH
- FETCH (11 cycles) → WAIT_BLUR
- WAIT_BLUR —`blur_valid_in`→ WRITE
- WRITE → ADVANCE
- ADVANCE → FETCH, or → IDLE (end of octave)

**Counters:** `x`, `y` in [0, W-1] with W = `IMG_W>>octave`; `blur_level` in [0, `NUM_BLURS`-1]; `octave` in [0, `NUM_OCTAVES`-1].

**Halves:**
- Read half = `blur_level[0]`; write half = `~blur_level[0]`.
- Half base = half ? W*W : 0.
- Blur level 0 reads the loaded source image.

**FETCH:**
- Cycles 0..8 issue reads in row-major order (dy = -1, 0, +1 outer; dx = -1, 0, +1 inner).
- Address = base + ry*W + rx, where rx = clamp(x+dx, 0, W-1) and ry = clamp(y+dy, 0, W-1).
- `pixel_in` is captured on cycles 2..10 into the matching row/column slot.

**Handoff to blur:** `kernel_valid_out` pulses on the cycle FETCH exits to WAIT_BLUR. Rows hold stable until the next FETCH capture.

**WRITE:** `wr_en_out`=1 for one cycle, with:
- `wr_addr_out` = write base + y*W + x
- `wr_data_out` = captured `blur_pixel_in`
- `blur_level_out` = current `blur_level`

**ADVANCE** (increment order):
- x++.
- On x = W-1: x←0, y++.
- On y = W-1: y←0, `blur_level`++.
- On `blur_level` = `NUM_BLURS`-1: `blur_level`←0, pulse `octave_done_out`, `octave`++, go to IDLE.
- If that was the last octave: `octave`←0 and `pyramid_done_out`←1.

**Ignored inputs:**
- `go_in` while `busy_out`=1 is ignored.
- `blur_valid_in` outside WAIT_BLUR is ignored and sets `error_out`.

**Arithmetic:** all address math is unsigned at `ADDR_W` bits; clamping is done before multiplication.

## Timing
- **Reset** (async assert, sync deassert usage):
  - state = IDLE; all counters = 0.
  - Every output = 0, including the row registers.
  - Applied mid-operation, it aborts immediately: no further reads or writes.
- **Startup:** first `rd_en_out` occurs the cycle after `go_in` is sampled.
- **Per-pixel throughput:** 11 (FETCH) + blur latency L + 1 (WRITE) + 1 (ADVANCE) cycles. With `gaussian` L = 4, that is 17 cycles/pixel.
- **Write timing:** `wr_en_out` is asserted the cycle after `blur_valid_in` is sampled.
- **Pulse timing:** `octave_done_out` and `pyramid_done_out` rise in the ADVANCE cycle of the last pixel.
- **Read/write overlap:** reads and writes never overlap in the same cycle.

## Test plan
- **Reset:** assert `rst_n_in`=0 mid-FETCH → `rd_en_out`, `busy_out`, `kernel_valid_out` and `wr_en_out` drop to 0 asynchronously; after release, the block stays in IDLE.
- **Corner kernel** (`IMG_W`=16, octave 0, pixel (0,0), BRAM model with value = address[7:0]) → read addresses 0,0,1,0,0,1,16,16,17; rows = {00,00,01},{00,00,01},{10,10,11}.
- **Far corner** (15,15) at blur level 1 → read base 256; first address 256+14*16+14 = 494; clamped addresses repeat 511; write address 255.
- **Full octave** (`IMG_W`=16, L=4, `NUM_BLURS`=2) → 512 writes; write halves alternate 1 then 0; `octave_done_out` pulses once, 512*17 cycles after `go_in`.
- **Full pyramid** (`NUM_OCTAVES`=2) → octave 1 uses W=8 and `rd_octave_out`=1; `pyramid_done_out` is set after octave 1; a new `go_in` clears it.
- **Protocol errors:** `go_in` during WAIT_BLUR → no effect; a stray `blur_valid_in` in FETCH → `error_out`=1, held until reset, with no write issued.
